timer_arbiter: RTL and testbench

TIMER_ARBITER -- requirements
Module: timer_arbiter

---
 rtl/timer_arbiter.sv | 153 +++++++++++++++
 tb/tb_timer_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_arbiter.sv
// Round-robin arbiter granting a single shared prescaled delay timer to one of
// NUM_REQ requesters. The owner gets a one-cycle done pulse when its delay expires.
module timer_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int CNT_WIDTH = 16,
  parameter int PRESCALE  = 100000
) (
  input  logic                           clk_in,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*CNT_WIDTH-1:0]   delay,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             done,
  output logic                           busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     rr_q, rr_d;
  logic [PTR_W-1:0]     win_q, win_d;
  logic [CNT_WIDTH-1:0] rem_q, rem_d;
  logic [PS_W-1:0]      presc_q, presc_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 busy_q, busy_d;

  logic                 win_found;
  logic [PTR_W-1:0]     win_idx;
  logic [PTR_W-1:0]     cand;
  logic [CNT_WIDTH-1:0] win_delay;
  logic                 tick;
  logic                 abort;
  logic                 last_tick;
  logic [PTR_W-1:0]     next_ptr;

  // Winner search: first set req bit at or after rr_q, wrapping.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PTR_W'((int'(rr_q) + i) % NUM_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_delay = delay[int'(win_idx)*CNT_WIDTH +: CNT_WIDTH];
  assign tick      = (presc_q == PS_W'(PRESCALE - 1));
  assign abort     = !req[win_q];
  assign last_tick = tick && (rem_q == CNT_WIDTH'(1));
  assign next_ptr  = PTR_W'((int'(win_q) + 1) % NUM_REQ);

  // State and datapath registers; reset is synchronous and wins over everything.
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      win_q   <= '0;
      rem_q   <= '0;
      presc_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
      rem_q   <= rem_d;
      presc_q <= presc_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    win_d   = win_q;
    rem_d   = rem_q;
    presc_d = presc_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          win_d   = win_idx;
          rem_d   = win_delay;
          presc_d = '0;
          state_d = (win_delay != '0) ? COUNT : DONE;
        end
      end
      COUNT: begin
        if (abort) begin
          state_d = IDLE;
          rr_d    = next_ptr;
        end else begin
          presc_d = tick ? '0 : presc_q + PS_W'(1);
          if (tick) begin
            rem_d = rem_q - CNT_WIDTH'(1);
            if (last_tick) state_d = DONE;
          end
        end
      end
      DONE: begin
        // A zero delay enters DONE with done still low; the pulse comes one cycle later.
        if (done_q) begin
          state_d = IDLE;
          rr_d    = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered-output next values.
  always_comb begin
    grant_d = grant_q;
    done_d  = '0;
    busy_d  = (state_d != IDLE);
    unique case (state_q)
      IDLE: begin
        grant_d = win_found ? (NUM_REQ'(1) << win_idx) : '0;
      end
      COUNT: begin
        if (abort)          grant_d = '0;
        else if (last_tick) done_d  = grant_q;
      end
      DONE: begin
        if (done_q) grant_d = '0;
        else        done_d  = grant_q;
      end
      default: grant_d = '0;
    endcase
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter at PRESCALE=4, CNT_WIDTH=8, NUM_REQ=4:
// a table of single transactions plus hand-written multi-cycle sequences.
module tb_timer_arbiter;

  localparam int NR = 4;
  localparam int CW = 8;
  localparam int PS = 4;

  logic             clk_in = 1'b0;
  logic             reset  = 1'b0;
  logic [NR-1:0]    req    = '0;
  logic [NR*CW-1:0] delay  = '0;
  logic [NR-1:0]    grant;
  logic [NR-1:0]    done;
  logic             busy;

  int cyc     = 0;
  int n_check = 0;
  int n_fail  = 0;

  timer_arbiter #(.NUM_REQ(NR), .CNT_WIDTH(CW), .PRESCALE(PS)) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .req    (req),
    .delay  (delay),
    .grant  (grant),
    .done   (done),
    .busy   (busy)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    logic [NR-1:0]    req;
    logic [NR*CW-1:0] delay;
    logic [NR-1:0]    exp_grant;
    int               exp_lat;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_check++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One-hot grant/done and done only on the granted index, every cycle out of reset.
  always @(negedge clk_in) begin
    if (reset) begin
      check("onehot_grant", 32'($onehot0(grant)), 32'd1);
      check("onehot_done", 32'($onehot0(done)), 32'd1);
      check("done_on_grant", 32'(done & ~grant), 32'd0);
    end
  end

  task automatic wait_grant(input int lim, output int t);
    t = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk_in);
      if (grant != '0) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int lim, output int t);
    t = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk_in);
      if (done != '0) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = '0;
    @(negedge clk_in);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk_in);
    reset = 1'b1;
  endtask

  task automatic run_txn(input vec_t v);
    int t0, t1;
    req   = v.req;
    delay = v.delay;
    wait_grant(20, t0);
    check("txn_grant", 32'(grant), 32'(v.exp_grant));
    check("txn_busy", 32'(busy), 32'd1);
    delay = '1;  // changing delay mid-operation must not matter
    wait_done(2000, t1);
    check("txn_done_idx", 32'(done), 32'(v.exp_grant));
    check("txn_grant_at_done", 32'(grant), 32'(v.exp_grant));
    check("txn_latency", 32'(t1 - t0), 32'(v.exp_lat));
    req = '0;
    @(negedge clk_in);
    check("txn_post_grant", 32'(grant), 32'd0);
    check("txn_post_busy", 32'(busy), 32'd0);
    check("txn_post_done", 32'(done), 32'd0);
  endtask

  initial begin
    int t0, t1, prev;
    logic [NR-1:0] fair_exp [4];

    vecs[0] = '{req: 4'b0001, delay: 32'h0000_0003, exp_grant: 4'b0001, exp_lat: 3 * PS};
    vecs[1] = '{req: 4'b0100, delay: 32'h0700_0509, exp_grant: 4'b0100, exp_lat: 1};
    vecs[2] = '{req: 4'b1000, delay: 32'h0102_0304, exp_grant: 4'b1000, exp_lat: 1 * PS};
    vecs[3] = '{req: 4'b0010, delay: 32'h0000_0200, exp_grant: 4'b0010, exp_lat: 2 * PS};
    vecs[4] = '{req: 4'b0001, delay: 32'h0000_00FF, exp_grant: 4'b0001, exp_lat: 255 * PS};

    do_reset();
    @(negedge clk_in);

    // Table of single-requester transactions.
    for (int k = 0; k < 5; k++) run_txn(vecs[k]);

    // All four request at once after reset: served 0,1,2,3 with a one-cycle gap.
    do_reset();
    req   = 4'b1111;
    delay = 32'h0101_0101;
    prev  = 0;
    for (int k = 0; k < NR; k++) begin
      wait_grant(20, t0);
      check("rr_grant", 32'(grant), 32'(1 << k));
      if (k > 0) check("rr_gap", 32'(t0 - prev), 32'd2);
      wait_done(50, t1);
      check("rr_done", 32'(done), 32'(1 << k));
      check("rr_latency", 32'(t1 - t0), 32'(PS));
      prev   = t1;
      req[k] = 1'b0;
    end
    @(negedge clk_in);
    check("rr_idle_busy", 32'(busy), 32'd0);

    // Abort: requester 1 drops req mid-count while 2 is pending (rr_ptr is 0 here).
    req   = 4'b0110;
    delay = 32'h0001_0500;
    wait_grant(20, t0);
    check("abort_grant1", 32'(grant), 32'b0010);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_in);
      check("abort_no_done", 32'(done), 32'd0);
    end
    req = 4'b0100;
    @(negedge clk_in);
    check("abort_grant_clr", 32'(grant), 32'd0);
    check("abort_busy_clr", 32'(busy), 32'd0);
    check("abort_done_none", 32'(done), 32'd0);
    @(negedge clk_in);
    check("abort_grant2", 32'(grant), 32'b0100);
    t0 = cyc;
    wait_done(50, t1);
    check("abort_done2", 32'(done), 32'b0100);
    check("abort_lat2", 32'(t1 - t0), 32'(PS));
    req = '0;
    @(negedge clk_in);

    // Fairness: 0 and 2 held continuously (rr_ptr is 3 here) -> 0,2,0,2.
    fair_exp[0] = 4'b0001; fair_exp[1] = 4'b0100;
    fair_exp[2] = 4'b0001; fair_exp[3] = 4'b0100;
    req   = 4'b0101;
    delay = 32'h0001_0001;
    for (int k = 0; k < 4; k++) begin
      wait_grant(20, t0);
      check("fair_grant", 32'(grant), 32'(fair_exp[k]));
      wait_done(50, t1);
      check("fair_done", 32'(done), 32'(fair_exp[k]));
    end
    req = '0;
    @(negedge clk_in);

    // Move rr_ptr to 2 via a zero-delay grant to requester 1.
    run_txn('{req: 4'b0010, delay: 32'h0, exp_grant: 4'b0010, exp_lat: 1});

    // Reset during COUNT of requester 3.
    req   = 4'b1000;
    delay = 32'h0300_0000;
    wait_grant(20, t0);
    check("mid_rst_grant", 32'(grant), 32'b1000);
    repeat (3) @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);
    check("mid_rst_grant0", 32'(grant), 32'd0);
    check("mid_rst_done0", 32'(done), 32'd0);
    check("mid_rst_busy0", 32'(busy), 32'd0);
    req   = 4'b0110;
    delay = 32'h0001_0100;
    @(negedge clk_in);
    check("mid_rst_hold_done", 32'(done), 32'd0);
    reset = 1'b1;
    wait_grant(20, t0);
    check("post_rst_grant", 32'(grant), 32'b0010);
    wait_done(50, t1);
    check("post_rst_done", 32'(done), 32'b0010);
    req = '0;
    repeat (3) @(negedge clk_in);

    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule
